// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register. It owns the PC,
//   drives a multi-cycle instruction-memory request handshake, and hands
//   instr / IF_ID_PC_2 / IF_ID_HALT to the decode stage. Decode can redirect
//   fetch (branch_taken), bubble IF/ID (IF_flush) or stall it (IF_ID_nowrite).
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active low
//   branch_taken   redirect request from decode
//   branch_PC      redirect target
//   IF_flush       load a bubble into IF/ID this cycle
//   IF_ID_nowrite  decode stall: IF/ID and PC hold
//   imem_data      fetched word, valid when imem_done is high
//   imem_done      current request complete (may be same cycle as request)
//   imem_addr      registered request address
//   imem_rd        request active
//   instr          IF/ID instruction
//   IF_ID_PC_2     IF/ID fetched PC + 2
//   IF_ID_HALT     IF/ID instruction is a HALT
//   err            sticky misaligned-fetch error

module if_fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] NOP_INSTR   = 16'h0800,
  parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic [15:0] branch_PC,
  input  logic        IF_flush,
  input  logic        IF_ID_nowrite,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  output logic [15:0] instr,
  output logic [15:0] IF_ID_PC_2,
  output logic        IF_ID_HALT,
  output logic        err
);

  typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

  state_t      r_state, w_stateNext;
  logic [15:0] r_pc, w_pcNext;
  logic [15:0] r_imemAddr, w_imemAddrNext;
  logic [15:0] r_instr, w_instrNext;
  logic [15:0] r_pc2, w_pc2Next;
  logic [15:0] r_skid, w_skidNext;
  logic        r_halt, w_haltNext;
  logic        r_err, w_errNext;
  logic        r_squash, w_squashNext;
  // Low for the first cycle after reset so a late completion of the
  // abandoned pre-reset access is never mistaken for a new fetch.
  logic        r_started;

  logic [15:0] w_pcPlus2;
  logic        w_redirect;
  logic        w_bubble;
  logic        w_load;
  logic [15:0] w_loadData;
  logic        w_issue;
  logic [15:0] w_issueAddr;

  assign w_pcPlus2  = r_pc + 16'd2;
  assign w_redirect = branch_taken | IF_flush;

  // State register: FSM state plus all datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_imemAddr <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_pc2      <= 16'h0000;
      r_halt     <= 1'b0;
      r_err      <= 1'b0;
      r_squash   <= 1'b0;
      r_skid     <= 16'h0000;
      r_started  <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_pc       <= w_pcNext;
      r_imemAddr <= w_imemAddrNext;
      r_instr    <= w_instrNext;
      r_pc2      <= w_pc2Next;
      r_halt     <= w_haltNext;
      r_err      <= w_errNext;
      r_squash   <= w_squashNext;
      r_skid     <= w_skidNext;
      r_started  <= 1'b1;
    end
  end

  // Next-state logic. Each state only decides whether to bubble IF/ID, load
  // a fetched word into IF/ID, or issue a new request; the shared code after
  // the case applies those decisions so every path follows the same rules.
  always_comb begin
    w_stateNext    = r_state;
    w_pcNext       = r_pc;
    w_imemAddrNext = r_imemAddr;
    w_instrNext    = r_instr;
    w_pc2Next      = r_pc2;
    w_haltNext     = r_halt;
    w_errNext      = r_err;
    w_squashNext   = r_squash;
    w_skidNext     = r_skid;
    w_bubble       = w_redirect;
    w_load         = 1'b0;
    w_loadData     = imem_data;
    w_issue        = 1'b0;
    w_issueAddr    = r_imemAddr;

    if (branch_taken) begin
      w_pcNext = branch_PC;
    end

    if (!r_started) begin
      if (branch_taken) begin
        w_issue     = 1'b1;
        w_issueAddr = branch_PC;
      end
    end else begin
      unique case (r_state)
        FETCH: begin
          if (!imem_done) begin
            // The access in flight cannot be aborted; remember to drop it.
            if (!IF_ID_nowrite) w_bubble = 1'b1;
            if (branch_taken)   w_squashNext = 1'b1;
          end else if (r_squash || w_redirect) begin
            w_bubble     = 1'b1;
            w_squashNext = 1'b0;
            w_issue      = 1'b1;
            w_issueAddr  = branch_taken ? branch_PC : r_pc;
          end else if (!IF_ID_nowrite) begin
            w_load     = 1'b1;
            w_loadData = imem_data;
          end else begin
            w_skidNext  = imem_data;
            w_stateNext = HOLD;
          end
        end
        HOLD: begin
          if (branch_taken) begin
            w_issue     = 1'b1;
            w_issueAddr = branch_PC;
          end else if (!IF_flush && !IF_ID_nowrite) begin
            w_load     = 1'b1;
            w_loadData = r_skid;
          end
        end
        HALTED: begin
          if (branch_taken) begin
            w_issue     = 1'b1;
            w_issueAddr = branch_PC;
          end
        end
        default: w_stateNext = FETCH;
      endcase
    end

    if (w_load) begin
      w_instrNext = w_loadData;
      w_pc2Next   = w_pcPlus2;
      w_haltNext  = (w_loadData[15:11] == HALT_OPCODE);
      w_pcNext    = w_pcPlus2;
      if (w_loadData[15:11] == HALT_OPCODE) begin
        w_stateNext = HALTED;
      end else begin
        w_issue     = 1'b1;
        w_issueAddr = w_pcPlus2;
      end
    end

    // A misaligned target is never presented to memory.
    if (w_issue) begin
      if (w_issueAddr[0]) begin
        w_errNext   = 1'b1;
        w_stateNext = HALTED;
        if (!IF_ID_nowrite) w_bubble = 1'b1;
      end else begin
        w_imemAddrNext = w_issueAddr;
        w_stateNext    = FETCH;
      end
    end

    if (w_bubble) begin
      w_instrNext = NOP_INSTR;
      w_pc2Next   = 16'h0000;
      w_haltNext  = 1'b0;
    end
  end

  // Output logic.
  always_comb begin
    imem_rd    = rst && r_started && (r_state == FETCH);
    imem_addr  = r_imemAddr;
    instr      = r_instr;
    IF_ID_PC_2 = r_pc2;
    IF_ID_HALT = r_halt;
    err        = r_err;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage
//   Directed, table-driven bench for if_fetch_stage. Each record holds the
//   inputs for one clock cycle and the outputs expected just after that edge.
module tb_if_fetch_stage;

  typedef struct {
    logic        rst;
    logic        br;
    logic [15:0] brPc;
    logic        flush;
    logic        nowrite;
    logic        done;
    logic [15:0] data;
    logic [15:0] expAddr;
    logic        expRd;
    logic [15:0] expInstr;
    logic [15:0] expPc2;
    logic        expHalt;
    logic        expErr;
  } vector_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_PC = 16'h0000;
  logic        IF_flush = 1'b0;
  logic        IF_ID_nowrite = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        imem_done = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] instr;
  logic [15:0] IF_ID_PC_2;
  logic        IF_ID_HALT;
  logic        err;

  int checkCount = 0;
  int passCount  = 0;

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_PC(branch_PC),
    .IF_flush(IF_flush), .IF_ID_nowrite(IF_ID_nowrite), .imem_data(imem_data),
    .imem_done(imem_done), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .instr(instr), .IF_ID_PC_2(IF_ID_PC_2), .IF_ID_HALT(IF_ID_HALT), .err(err)
  );

  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vector_t mk(
    input logic r, input logic b, input logic [15:0] bp, input logic f,
    input logic nw, input logic d, input logic [15:0] dat,
    input logic [15:0] eA, input logic eR, input logic [15:0] eI,
    input logic [15:0] eP, input logic eH, input logic eE);
    vector_t v;
    v.rst = r; v.br = b; v.brPc = bp; v.flush = f; v.nowrite = nw;
    v.done = d; v.data = dat;
    v.expAddr = eA; v.expRd = eR; v.expInstr = eI; v.expPc2 = eP;
    v.expHalt = eH; v.expErr = eE;
    return v;
  endfunction

  // Drive one cycle of inputs on the falling edge, then step past the
  // rising edge so registered outputs have settled.
  task automatic applyStimulus(input vector_t v);
    @(negedge clk);
    rst           = v.rst;
    branch_taken  = v.br;
    branch_PC     = v.brPc;
    IF_flush      = v.flush;
    IF_ID_nowrite = v.nowrite;
    imem_done     = v.done;
    imem_data     = v.data;
    @(posedge clk);
    #1;
  endtask

  task automatic checkField(input string tag, input string field,
                            input logic [15:0] act, input logic [15:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s %s: got %h, expected %h", tag, field, act, exp);
  endtask

  task automatic checkOutput(input string tag, input vector_t v);
    checkField(tag, "imem_addr",  imem_addr,           v.expAddr);
    checkField(tag, "imem_rd",    {15'd0, imem_rd},    {15'd0, v.expRd});
    checkField(tag, "instr",      instr,               v.expInstr);
    checkField(tag, "IF_ID_PC_2", IF_ID_PC_2,          v.expPc2);
    checkField(tag, "IF_ID_HALT", {15'd0, IF_ID_HALT}, {15'd0, v.expHalt});
    checkField(tag, "err",        {15'd0, err},        {15'd0, v.expErr});
  endtask

  initial begin
    vector_t vecs[$];
    vector_t v;

    //            rst br brPc     fl nw dn data       addr     rd instr    pc2      h  e
    // reset, late done ignored, then 1-cycle memory
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0800, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0800, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'hDEAD, 16'h0000, 1, 16'h0800, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h4000, 16'h0002, 1, 16'h4000, 16'h0002, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h4100, 16'h0004, 1, 16'h4100, 16'h0004, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h4200, 16'h0006, 1, 16'h4200, 16'h0006, 0, 0));
    // 3-cycle latency: address stable, two bubbles
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0006, 1, 16'h0800, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0006, 1, 16'h0800, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h4300, 16'h0008, 1, 16'h4300, 16'h0008, 0, 0));
    // stall for 4 cycles, completion lands in the skid buffer
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 0, 16'h0000, 16'h0008, 1, 16'h4300, 16'h0008, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 1, 16'h5A5A, 16'h0008, 0, 16'h4300, 16'h0008, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 0, 16'h0000, 16'h0008, 0, 16'h4300, 16'h0008, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 1, 16'hFFFF, 16'h0008, 0, 16'h4300, 16'h0008, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h000A, 1, 16'h5A5A, 16'h000A, 0, 0));
    // redirect to 0x10, then redirect to 0x40 while 0x10 is in flight
    vecs.push_back(mk(1, 1, 16'h0010, 0, 0, 1, 16'h7777, 16'h0010, 1, 16'h0800, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0040, 0, 0, 0, 16'h0000, 16'h0010, 1, 16'h0800, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0010, 1, 16'h0800, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h1234, 16'h0040, 1, 16'h0800, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h4400, 16'h0042, 1, 16'h4400, 16'h0042, 0, 0));
    // HALT at PC 8, stays halted, branch to 0x20 resumes
    vecs.push_back(mk(1, 1, 16'h0008, 0, 0, 1, 16'h7777, 16'h0008, 1, 16'h0800, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0008, 0, 16'h0000, 16'h000A, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0008, 0, 16'h0000, 16'h000A, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h4500, 16'h0008, 0, 16'h0000, 16'h000A, 1, 0));
    vecs.push_back(mk(1, 1, 16'h0020, 0, 0, 0, 16'h0000, 16'h0020, 1, 16'h0800, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h4600, 16'h0022, 1, 16'h4600, 16'h0022, 0, 0));
    // flush overrides stall
    vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 0, 16'h0000, 16'h0022, 1, 16'h0800, 16'h0000, 0, 0));
    // PC wrap 0xFFFE + 2 -> 0x0000
    vecs.push_back(mk(1, 1, 16'hFFFE, 0, 0, 1, 16'h7777, 16'hFFFE, 1, 16'h0800, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h4800, 16'h0000, 1, 16'h4800, 16'h0000, 0, 0));
    // misaligned redirect: err sticky, halted, no request
    vecs.push_back(mk(1, 1, 16'h0031, 0, 0, 1, 16'h7777, 16'h0000, 0, 16'h0800, 16'h0000, 0, 1));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h4000, 16'h0000, 0, 16'h0800, 16'h0000, 0, 1));
    // only reset clears err; fetch restarts at 0
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0800, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'hDEAD, 16'h0000, 1, 16'h0800, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h4700, 16'h0002, 1, 16'h4700, 16'h0002, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Hand sequence: reset while a request is outstanding.
    v = mk(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0002, 1, 16'h0800, 16'h0000, 0, 0);
    applyStimulus(v); checkOutput("midreq_pending", v);
    v = mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0800, 16'h0000, 0, 0);
    applyStimulus(v); checkOutput("midreq_reset", v);
    v = mk(1, 0, 16'h0000, 0, 0, 1, 16'hDEAD, 16'h0000, 1, 16'h0800, 16'h0000, 0, 0);
    applyStimulus(v); checkOutput("midreq_late_done", v);
    v = mk(1, 0, 16'h0000, 0, 0, 1, 16'h4900, 16'h0002, 1, 16'h4900, 16'h0002, 0, 0);
    applyStimulus(v); checkOutput("midreq_refetch", v);

    // Hand sequence: HALT with nonzero low bits, then no requests for a while.
    v = mk(1, 0, 16'h0000, 0, 0, 1, 16'h0123, 16'h0002, 0, 16'h0123, 16'h0004, 1, 0);
    applyStimulus(v); checkOutput("halt_enter", v);
    for (int k = 0; k < 4; k++) begin
      v = mk(1, 0, 16'h0000, 0, 0, 1, 16'h4A00, 16'h0002, 0, 16'h0123, 16'h0004, 1, 0);
      applyStimulus(v);
      checkOutput($sformatf("halt_idle%0d", k), v);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage.
- Owns the PC and drives a multi-cycle instruction-cache/memory request handshake.
- Presents instr, IF_ID_PC_2 and IF_ID_HALT to decode.
- Accepts branch redirect, IF_flush and IF_ID_nowrite (stall) from decode.

Parameters:
- RESET_PC, 16'h0000: PC value after reset.
- NOP_INSTR, 16'h0800: bubble encoding (opcode 5'b00001, remaining bits zero).
- HALT_OPCODE, 5'b00000: opcode in instr[15:11] that stops fetch.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-low (rst==0 at a rising edge resets)
- branch_taken  in  1  decode redirect request
- branch_PC  in  16  redirect target
- IF_flush  in  1  load bubble into IF/ID this cycle
- IF_ID_nowrite  in  1  decode stall; IF/ID register and PC hold
- imem_data  in  16  fetched instruction, valid only when imem_done==1
- imem_done  in  1  current request complete; may assert in the same cycle as the request
- imem_addr  out  16  request address, registered, stable while imem_rd==1 and imem_done==0
- imem_rd  out  1  request active
- instr  out  16  IF/ID instruction
- IF_ID_PC_2  out  16  IF/ID fetched-PC+2
- IF_ID_HALT  out  1  IF/ID instruction is HALT
- err  out  1  sticky misaligned-fetch error

Behaviour:
- Reset values: PC = RESET_PC, imem_addr = RESET_PC, imem_rd = 0, instr = NOP_INSTR, IF_ID_PC_2 = 0, IF_ID_HALT = 0, err = 0, squash = 0, state = FETCH.
- imem_rd is 1 only in FETCH with rst high. It is 0 in HOLD and HALTED and in the cycle(s) rst is low.
- Input priority each cycle: rst > (branch_taken | IF_flush) > IF_ID_nowrite > normal.
- IF_flush or branch_taken: IF/ID loads instr = NOP_INSTR, IF_ID_HALT = 0, IF_ID_PC_2 = 0. This overrides IF_ID_nowrite.
- branch_taken: PC <= branch_PC in every state.
- All PC arithmetic is 16-bit modulo; 16'hFFFE + 2 wraps to 16'h0000.
- FETCH, imem_done == 0:
  - IF/ID loads a bubble if IF_ID_nowrite == 0; otherwise IF/ID holds.
  - On branch_taken, set squash = 1. imem_addr holds the in-flight address; the memory access is never aborted.
- FETCH, imem_done == 1 and (squash | branch_taken):
  - Discard imem_data; clear squash.
  - imem_addr <= next PC (branch_PC if branch_taken this cycle, else PC). Stay in FETCH.
- FETCH, imem_done == 1, no squash, IF_ID_nowrite == 0:
  - IF/ID loads instr = imem_data, IF_ID_PC_2 = PC+2, IF_ID_HALT = (imem_data[15:11] == HALT_OPCODE).
  - PC <= PC+2.
  - If HALT, go to HALTED; otherwise imem_addr <= PC+2 and stay in FETCH (back-to-back requests, one instruction per cycle at 1-cycle latency).
- FETCH, imem_done == 1, no squash, IF_ID_nowrite == 1:
  - Capture imem_data into the skid buffer; IF/ID holds; go to HOLD.
- HOLD:
  - While IF_ID_nowrite == 1, hold everything.
  - When IF_ID_nowrite == 0: IF/ID loads the skid buffer (same rules as the normal-load case); PC <= PC+2; then to HALTED if HALT, else imem_addr <= PC+2 and to FETCH.
  - branch_taken: discard skid buffer, PC <= branch_PC, imem_addr <= branch_PC, go to FETCH.
- HALTED:
  - PC and imem_addr frozen; IF/ID holds unless flushed.
  - branch_taken leaves HALTED (the HALT was wrong-path): PC <= branch_PC, imem_addr <= branch_PC, go to FETCH.
  - Only reset or branch_taken exits HALTED.
- Misalignment:
  - Any new request address with bit0 == 1 sets err = 1 (sticky until reset) and goes to HALTED with no request issued.
  - IF/ID loads a bubble unless IF_ID_nowrite == 1.
- Reset mid-request: the outstanding memory access is abandoned. A late imem_done in the first post-reset cycle is ignored; the next request is issued at RESET_PC one cycle after rst returns high.

Test Plan:
- Reset then 1-cycle memory returning 0x4000, 0x4100, 0x4200 -> instr sequence 0x4000/0x4100/0x4200 on consecutive cycles; IF_ID_PC_2 = 2, 4, 6; imem_addr = 0, 2, 4.
- 3-cycle memory latency -> imem_addr stable for 3 cycles; two NOP 0x0800 bubbles between valid instrs; PC advances by exactly 2 per instruction.
- IF_ID_nowrite held 4 cycles while done arrives with 0x5A5A -> imem_rd = 0 in HOLD; IF/ID unchanged; 0x5A5A appears the cycle after stall release; PC_2 correct.
- branch_taken with branch_PC = 0x0040 mid-request at addr 0x0010 (done 2 cycles later with 0x1234) -> 0x1234 never reaches instr; next request at 0x0040; bubble in IF/ID on the redirect cycle.
- Fetch 0x0000 (HALT) at PC 8 -> IF_ID_HALT = 1, PC_2 = 0x000A, imem_rd = 0 thereafter; later branch_taken to 0x0020 resumes fetch at 0x0020.
- branch_PC = 0x0031 -> err = 1 and stays 1; state HALTED; no request issued; only rst low clears err, and fetch then restarts at 0x0000.
